// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: op codes, flag/entry types and helpers shared by the ALU flag stage.
// Rev 1.0
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    alu_flags_t           flags;
    logic                 arith;
    logic                 set_flags;
  } alu_entry_t;

  function automatic logic is_arith(input logic [2:0] cntrl);
    return (cntrl == ALU_ADD) || (cntrl == ALU_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// pipe_skid_buf: generic 2-entry FIFO-ordered valid/ready buffer with registered in_ready.
// Rev 1.0
module pipe_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  assign push = in_valid && ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  // Gate the head so an empty buffer presents zero rather than a stale entry.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/alu_flag_stage.sv
`default_nettype none
// alu_flag_stage: buffers ALU results, derives N/Z/V/C per entry, commits flags on retire.
// Rev 1.0
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout1,
  input  logic             alu_cout0,
  input  logic [2:0]       alu_cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       res_flags,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c
);

  localparam int ENTRY_W = $bits(alu_entry_t);

  if (WIDTH < 2 || WIDTH > ALU_WIDTH) begin : g_width_check
    $error("alu_flag_stage: WIDTH out of range");
  end

  alu_entry_t   in_entry, head;
  logic [ENTRY_W-1:0] in_bits, head_bits;
  alu_flags_t   flags_q, flags_d;
  logic         arith;

  always_comb begin
    arith              = is_arith(alu_cntrl);
    in_entry           = '0;
    in_entry.result    = ALU_WIDTH'(alu_out);
    in_entry.flags.n   = alu_out[WIDTH-1];
    in_entry.flags.z   = (alu_out == '0);
    // V/C stay zero for logical ops; the arith bit marks them as not produced.
    in_entry.flags.v   = arith & (alu_cout1 ^ alu_cout0);
    in_entry.flags.c   = arith & alu_cout1;
    in_entry.arith     = arith;
    in_entry.set_flags = set_flags;
  end

  assign in_bits = in_entry;
  assign head    = head_bits;

  pipe_skid_buf #(
    .DATA_W (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_bits)
  );

  always_comb begin
    flags_d = flags_q;
    if (out_valid && out_ready && head.set_flags) begin
      flags_d.n = head.flags.n;
      flags_d.z = head.flags.z;
      if (head.arith) begin
        flags_d.v = head.flags.v;
        flags_d.c = head.flags.c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign result    = head.result[WIDTH-1:0];
  assign res_flags = head.flags;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_v    = flags_q.v;
  assign flag_c    = flags_q.c;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_stage.sv
`default_nettype none
// tb_alu_flag_stage: directed vectors with hand-computed expectations for alu_flag_stage.
// Rev 1.0
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_out;
  logic        alu_cout1, alu_cout0;
  logic [2:0]  alu_cntrl;
  logic        set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  res_flags;
  logic        flag_n, flag_z, flag_v, flag_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_flag_stage #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_cout1 (alu_cout1),
    .alu_cout0 (alu_cout0),
    .alu_cntrl (alu_cntrl),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .res_flags (res_flags),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_c    (flag_c)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic c1, input logic c0,
                       input logic [2:0] op, input logic sf);
    in_valid  = v;
    alu_out   = d;
    alu_cout1 = c1;
    alu_cout0 = c0;
    alu_cntrl = op;
    set_flags = sf;
  endtask

  function automatic logic [63:0] flags4();
    return {60'd0, flag_n, flag_z, flag_v, flag_c};
  endfunction

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_result", result, 64'd0);
    check_val("rst_res_flags", {60'd0, res_flags}, 64'd0);
    check_val("rst_flags", flags4(), 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ADD producing signed overflow: N=1 Z=0 V=1 C=0
    out_ready = 1'b1;
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3'b010, 1'b1);
    tick();
    in_valid = 1'b0;
    check_val("add_out_valid", {63'd0, out_valid}, 64'd1);
    check_val("add_result", result, 64'h8000_0000_0000_0000);
    check_val("add_res_flags", {60'd0, res_flags}, 64'hA);
    check_val("add_flags_pre", flags4(), 64'd0);
    tick();
    check_val("add_flags", flags4(), 64'hA);
    check_val("add_drained", {63'd0, out_valid}, 64'd0);

    // SUB 5-5: N=0 Z=1 V=0 C=1
    drive(1'b1, 64'd0, 1'b1, 1'b1, 3'b011, 1'b1);
    tick();
    in_valid = 1'b0;
    check_val("sub_res_flags", {60'd0, res_flags}, 64'h5);
    tick();
    check_val("sub_flags", flags4(), 64'h5);

    // XOR all-ones: N/Z written, V/C held (0,1)
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b110, 1'b1);
    tick();
    in_valid = 1'b0;
    check_val("xor_res_flags", {60'd0, res_flags}, 64'h8);
    tick();
    check_val("xor_flags", flags4(), 64'h9);

    // XOR zero with set_flags=0: register must not move
    drive(1'b1, 64'd0, 1'b0, 1'b0, 3'b110, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check_val("xor_noset_flags", flags4(), 64'h9);

    // Backpressure: A=1, B=2 accepted, C=3 refused until space frees
    out_ready = 1'b0;
    drive(1'b1, 64'd1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    check_val("bp_ready_a", {63'd0, in_ready}, 64'd1);
    alu_out = 64'd2;
    tick();
    check_val("bp_ready_b", {63'd0, in_ready}, 64'd0);
    check_val("bp_head_b", result, 64'd1);
    alu_out = 64'd3;
    tick();
    check_val("bp_ready_c", {63'd0, in_ready}, 64'd0);
    check_val("bp_hold", result, 64'd1);
    check_val("bp_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    tick();
    check_val("bp_second", result, 64'd2);
    check_val("bp_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    check_val("bp_third", result, 64'd3);
    check_val("bp_third_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    tick();
    check_val("bp_empty", {63'd0, out_valid}, 64'd0);

    // Streaming at occupancy 1: one per cycle, order preserved
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'd100 + 64'(i), 1'b0, 1'b0, 3'b000, 1'b0);
      tick();
      check_val("stream_valid", {63'd0, out_valid}, 64'd1);
      check_val("stream_data", result, 64'd100 + 64'(i));
      check_val("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check_val("stream_drained", {63'd0, out_valid}, 64'd0);
    check_val("stream_flags", flags4(), 64'h9);

    // Reset with two entries buffered and flags non-zero
    out_ready = 1'b0;
    drive(1'b1, 64'd7, 1'b1, 1'b0, 3'b010, 1'b1);
    tick();
    alu_out = 64'd8;
    tick();
    check_val("mr_full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    check_val("mr_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("mr_flags", flags4(), 64'd0);
    check_val("mr_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("mr_result", result, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("mr_no_stale", {63'd0, out_valid}, 64'd0);
      check_val("mr_flags_hold", flags4(), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
